// File: rtl/stopwatch_pkg.sv
// Shared types and timing constants for the stopwatch input-conditioning blocks.
// Default constants assume a 50 MHz core clock.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_10MS_50MHZ = 500000;
    localparam int LONG_1S_50MHZ       = 50000000;

    // The debounced level stays high for as long as a press is accepted,
    // including while a release is still being qualified.
    function automatic logic is_pressed_state(input btn_state_t st);
        return (st == PRESSED) || (st == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for a single asynchronous level; latency 2 cycles.
// No backpressure: samples every cycle, synchronous active-high reset to 0.
module bit_synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button into a clean level plus press/release/long-press pulses.
// Latency DEBOUNCE_CYCLES+3 edges from stable input to output; no backpressure, outputs registered.
module button_debouncer
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int LONG_CYCLES     = LONG_1S_50MHZ,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic btn_level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic raw;
    logic s;

    btn_state_t        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DB_W-1:0]   db_inc;
    logic [HOLD_W-1:0] hold_inc;
    logic              long_fired_q, long_fired_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    assign raw = ACTIVE_LOW ? ~btn_i : btn_i;

    bit_synchronizer u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (raw),
        .q_o   (s)
    );

    assign db_inc   = db_cnt_q + DB_W'(1);
    assign hold_inc = hold_cnt_q + HOLD_W'(1);

    always_comb begin
        state_d      = state_q;
        db_cnt_d     = db_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        long_fired_d = long_fired_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_d       = 1'b0;

        case (state_q)
            IDLE: begin
                long_fired_d = 1'b0;
                if (s) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end

            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = PRESSED;
                    hold_cnt_d = '0;
                    press_d    = 1'b1;
                end else begin
                    db_cnt_d = db_inc;
                end
            end

            PRESSED: begin
                // Hold time saturates; the flag keeps a very long hold to one pulse.
                if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_inc;
                    if ((hold_inc == HOLD_LAST) && !long_fired_q) begin
                        long_d       = 1'b1;
                        long_fired_d = 1'b1;
                    end
                end
                if (!s) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = '0;
                end
            end

            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d      = IDLE;
                    long_fired_d = 1'b0;
                    release_d    = 1'b1;
                end else begin
                    db_cnt_d = db_inc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        level_d = is_pressed_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            long_fired_q <= long_fired_d;
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_q       <= long_d;
        end
    end

    assign btn_level_o  = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

    // Event pulses come from mutually exclusive transitions.
    a_pulses_exclusive: assert property (@(posedge clk) disable iff (reset)
        $onehot0({press_o, release_o, long_press_o}));

    a_long_while_pressed: assert property (@(posedge clk) disable iff (reset)
        long_press_o |-> btn_level_o);

endmodule

// File: tb/tb_button_debouncer.sv
// Scenario bench for button_debouncer with short debounce/long-press timing.
// Pulses are matched against a queue of expected (kind, cycle) entries.
module tb_button_debouncer;

    localparam int DB = 4;
    localparam int LC = 20;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic btn_i = 1'b1;
    logic btn_level_o;
    logic press_o;
    logic release_o;
    logic long_press_o;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [2:0] pulses;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LC),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_i        (btn_i),
        .btn_level_o  (btn_level_o),
        .press_o      (press_o),
        .release_o    (release_o),
        .long_press_o (long_press_o)
    );

    assign pulses = {long_press_o, release_o, press_o};

    // Every observed pulse must be the next expected one, at exactly its cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (pulses[k] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected: kind %0d at cycle %0d, required no pulse", k, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.kind !== k || mon_e.at !== cyc) begin
                        errors++;
                        $display("FAIL pulse_order: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                 k, cyc, mon_e.kind, mon_e.at);
                    end
                end
            end
        end
    end

    task automatic expect_pulse(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // t0 is the absolute index of the first edge that samples the new value.
    task automatic drive_btn(input logic pressed, output int t0);
        @(negedge clk);
        btn_i = pressed ? 1'b0 : 1'b1;
        t0 = cyc + 1;
    endtask

    task automatic drain(input string name);
        step(8);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected pulses missing, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        btn_i = 1'b1;
        step(3);
        checks++;
        if ({btn_level_o, press_o, release_o, long_press_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0000",
                     {btn_level_o, press_o, release_o, long_press_o});
        end
        reset = 1'b0;
        step(5);
        checks++;
        if (btn_level_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_level: got %b, required 0", btn_level_o);
        end
        drain("reset");
    endtask

    task automatic test_clean_press;
        int t0, t1;
        drive_btn(1'b1, t0);
        expect_pulse(K_PRESS, t0 + 6);
        wait_cyc(t0 + 5);
        checks++;
        if (btn_level_o !== 1'b0) begin
            errors++;
            $display("FAIL clean_level_early: got %b at cycle %0d, required 0", btn_level_o, cyc);
        end
        @(negedge clk);
        checks++;
        if (btn_level_o !== 1'b1) begin
            errors++;
            $display("FAIL clean_level_rise: got %b at cycle %0d, required 1", btn_level_o, cyc);
        end
        wait_cyc(t0 + 15);
        drive_btn(1'b0, t1);
        expect_pulse(K_REL, t1 + 6);
        wait_cyc(t1 + 5);
        checks++;
        if (btn_level_o !== 1'b1) begin
            errors++;
            $display("FAIL clean_level_hold: got %b at cycle %0d, required 1", btn_level_o, cyc);
        end
        @(negedge clk);
        checks++;
        if (btn_level_o !== 1'b0) begin
            errors++;
            $display("FAIL clean_level_fall: got %b at cycle %0d, required 0", btn_level_o, cyc);
        end
        drain("clean_press");
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            btn_i = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            checks++;
            if (btn_level_o !== 1'b0) begin
                errors++;
                $display("FAIL bounce_level: got %b at cycle %0d, required 0", btn_level_o, cyc);
            end
        end
        @(negedge clk);
        btn_i = 1'b1;
        step(10);
        checks++;
        if (btn_level_o !== 1'b0) begin
            errors++;
            $display("FAIL bounce_level_after: got %b, required 0", btn_level_o);
        end
        drain("bounce");
    endtask

    task automatic test_release_glitch;
        int t0, t1;
        drive_btn(1'b1, t0);
        expect_pulse(K_PRESS, t0 + 6);
        wait_cyc(t0 + 8);
        btn_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) btn_i = 1'b0;
            checks++;
            if (btn_level_o !== 1'b1) begin
                errors++;
                $display("FAIL glitch_level: got %b at cycle %0d, required 1", btn_level_o, cyc);
            end
            @(negedge clk);
        end
        drive_btn(1'b0, t1);
        expect_pulse(K_REL, t1 + 6);
        drain("release_glitch");
    endtask

    task automatic test_long_press;
        int t0, t1;
        drive_btn(1'b1, t0);
        expect_pulse(K_PRESS, t0 + 6);
        expect_pulse(K_LONG, t0 + 6 + 19);
        wait_cyc(t0 + 46);
        checks++;
        if (btn_level_o !== 1'b1) begin
            errors++;
            $display("FAIL long_level_hold: got %b, required 1", btn_level_o);
        end
        drive_btn(1'b0, t1);
        expect_pulse(K_REL, t1 + 6);
        wait_cyc(t1 + 6);
        checks++;
        if (btn_level_o !== 1'b0) begin
            errors++;
            $display("FAIL long_level_fall: got %b at cycle %0d, required 0", btn_level_o, cyc);
        end
        drain("long_press");
    endtask

    task automatic test_reset_mid;
        int t0, t1;
        drive_btn(1'b1, t0);
        wait_cyc(t0 + 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({btn_level_o, press_o, release_o, long_press_o} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b, required 0000",
                     {btn_level_o, press_o, release_o, long_press_o});
        end
        expect_pulse(K_PRESS, t0 + 12);
        wait_cyc(t0 + 11);
        checks++;
        if (btn_level_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_level_early: got %b at cycle %0d, required 0", btn_level_o, cyc);
        end
        @(negedge clk);
        checks++;
        if (btn_level_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_level_rise: got %b at cycle %0d, required 1", btn_level_o, cyc);
        end
        wait_cyc(t0 + 16);
        drive_btn(1'b0, t1);
        expect_pulse(K_REL, t1 + 6);
        drain("reset_mid");
    endtask

    task automatic test_back_to_back;
        int t0, t1, t2, t3;
        drive_btn(1'b1, t0);
        expect_pulse(K_PRESS, t0 + 6);
        wait_cyc(t0 + 8);
        drive_btn(1'b0, t1);
        expect_pulse(K_REL, t1 + 6);
        wait_cyc(t1 + 8);
        drive_btn(1'b1, t2);
        expect_pulse(K_PRESS, t2 + 6);
        wait_cyc(t2 + 8);
        drive_btn(1'b0, t3);
        expect_pulse(K_REL, t3 + 6);
        wait_cyc(t3 + 6);
        checks++;
        if (btn_level_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_level_final: got %b at cycle %0d, required 0", btn_level_o, cyc);
        end
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_long_press();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
